// File: rtl/rc4_pkg.sv
// Shared definitions for the RC4 stream engine: FSM states, S-box geometry
// and the key-length width helper.
package rc4_pkg;

  localparam int SBOX_SIZE = 256;
  localparam int BYTE_W    = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_KSA,
    ST_DROP,
    ST_STREAM,
    ST_ERR
  } state_t;

  // Width needed to hold a key length from 0 up to max_key_bytes inclusive.
  function automatic int klen_w(input int max_key_bytes);
    return $clog2(max_key_bytes + 1);
  endfunction

endpackage

// File: rtl/rc4_sbox.sv
// RC4 permutation state: 256 bytes held in flops. Two plain combinational read
// ports (i, j) plus a third read port for the output index t that returns the
// post-swap value, so a full PRGA step completes in one cycle.
module rc4_sbox
  import rc4_pkg::*;
(
  input  logic              clk,
  input  logic              init,
  input  logic              swap,
  input  logic [BYTE_W-1:0] idx_i,
  input  logic [BYTE_W-1:0] idx_j,
  input  logic [BYTE_W-1:0] idx_t,
  output logic [BYTE_W-1:0] val_i,
  output logic [BYTE_W-1:0] val_j,
  output logic [BYTE_W-1:0] val_t
);

  logic [BYTE_W-1:0] s [SBOX_SIZE];

  assign val_i = s[idx_i];
  assign val_j = s[idx_j];

  // Output-index read as it will look after this cycle's swap of S[i] and S[j].
  always_comb begin
    val_t = s[idx_t];
    if (idx_t == idx_j) val_t = val_i;
    if (idx_t == idx_i) val_t = val_j;
  end

  // Identity fill in one cycle, otherwise exchange S[i] and S[j] when asked.
  always_ff @(posedge clk) begin
    if (init) begin
      for (int n = 0; n < SBOX_SIZE; n++) s[n] <= BYTE_W'(n);
    end else if (swap) begin
      s[idx_i] <= val_j;
      s[idx_j] <= val_i;
    end
  end

endmodule

// File: rtl/rc4_stream.sv
// RC4 engine: variable-length key schedule, optional drop of the first DROP_N
// keystream bytes, then one keystream (or XORed data) byte per clock over
// valid/ready handshakes.
module rc4_stream
  import rc4_pkg::*;
#(
  parameter int MAX_KEY_BYTES = 32,
  parameter int DROP_N        = 0,
  parameter int KLEN_W        = klen_w(MAX_KEY_BYTES)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [MAX_KEY_BYTES*8-1:0] key,
  input  logic [KLEN_W-1:0]          key_length,
  input  logic                       mode,
  input  logic                       in_valid,
  input  logic [7:0]                 in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [7:0]                 out_data,
  input  logic                       out_ready,
  output logic                       busy,
  output logic                       key_err
);

  localparam logic [15:0]       DROP_LAST = 16'(DROP_N - 1);
  localparam logic [KLEN_W-1:0] KLEN_MAX  = KLEN_W'(MAX_KEY_BYTES);

  state_t state, state_nxt;

  logic [MAX_KEY_BYTES*8-1:0] key_l;
  logic [KLEN_W-1:0]          klen_l;
  logic [KLEN_W-1:0]          kidx;
  logic [KLEN_W-1:0]          kidx_inc;
  logic                       mode_l;
  logic [BYTE_W-1:0]          i;
  logic [BYTE_W-1:0]          j;
  logic [15:0]                drop_cnt;
  logic                       err_flag;

  logic                       vld_p0;
  logic [BYTE_W-1:0]          data_p0;

  logic                       legal;
  logic                       slot_free;
  logic                       ksa_step;
  logic                       stream_step;
  logic                       prga_step;
  logic [BYTE_W-1:0]          kbyte;
  logic [BYTE_W-1:0]          idx_i;
  logic [BYTE_W-1:0]          idx_j;
  logic [BYTE_W-1:0]          idx_t;
  logic [BYTE_W-1:0]          val_i;
  logic [BYTE_W-1:0]          val_j;
  logic [BYTE_W-1:0]          val_t;
  logic                       sbox_init;
  logic                       sbox_swap;

  assign legal     = (key_length != '0) && (key_length <= KLEN_MAX);
  assign slot_free = !vld_p0 || out_ready;
  assign kidx_inc  = kidx + KLEN_W'(1);

  assign ksa_step    = (state == ST_KSA);
  assign stream_step = (state == ST_STREAM) &&
                       (mode_l ? (in_valid && in_ready) : slot_free);
  assign prga_step   = (state == ST_DROP) || stream_step;

  // KSA walks i directly; PRGA pre-increments i before the lookups.
  assign idx_i = ksa_step ? i : i + 8'd1;
  assign idx_j = ksa_step ? (j + val_i + kbyte) : (j + val_i);
  assign idx_t = val_i + val_j;

  assign sbox_init = (state == ST_INIT);
  assign sbox_swap = rst_n && !start && (ksa_step || prga_step);

  assign out_valid = vld_p0;
  assign out_data  = data_p0;
  assign key_err   = err_flag;

  // Key byte mux: select byte kidx of the latched key.
  always_comb begin
    kbyte = '0;
    for (int b = 0; b < MAX_KEY_BYTES; b++) begin
      if (kidx == KLEN_W'(b)) kbyte = key_l[b*8 +: 8];
    end
  end

  rc4_sbox u_sbox (
    .clk   (clk),
    .init  (sbox_init),
    .swap  (sbox_swap),
    .idx_i (idx_i),
    .idx_j (idx_j),
    .idx_t (idx_t),
    .val_i (val_i),
    .val_j (val_j),
    .val_t (val_t)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; start overrides every state.
  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = legal ? ST_INIT : ST_ERR;
    end else begin
      case (state)
        ST_INIT: state_nxt = ST_KSA;
        ST_KSA:  if (i == 8'hFF) state_nxt = (DROP_N > 0) ? ST_DROP : ST_STREAM;
        ST_DROP: if (drop_cnt == DROP_LAST) state_nxt = ST_STREAM;
        default: state_nxt = state;
      endcase
    end
  end

  // State-decoded outputs.
  always_comb begin
    busy     = (state == ST_INIT) || (state == ST_KSA) || (state == ST_DROP);
    in_ready = (state == ST_STREAM) && mode_l && slot_free;
  end

  // Key capture on start; no reset needed since it is only read after a start.
  always_ff @(posedge clk) begin
    if (start) key_l <= key;
  end

  // Counters, error flag and output register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      i        <= '0;
      j        <= '0;
      kidx     <= '0;
      drop_cnt <= '0;
      klen_l   <= '0;
      mode_l   <= 1'b0;
      err_flag <= 1'b0;
      vld_p0   <= 1'b0;
      data_p0  <= '0;
    end else if (start) begin
      i        <= '0;
      j        <= '0;
      kidx     <= '0;
      drop_cnt <= '0;
      klen_l   <= key_length;
      mode_l   <= mode;
      err_flag <= !legal;
      vld_p0   <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          i        <= '0;
          j        <= '0;
          kidx     <= '0;
          drop_cnt <= '0;
        end
        ST_KSA: begin
          // i wraps 255 -> 0 on exit; j is cleared for the PRGA.
          i    <= i + 8'd1;
          j    <= (i == 8'hFF) ? '0 : idx_j;
          kidx <= (kidx_inc == klen_l) ? '0 : kidx_inc;
        end
        ST_DROP: begin
          i        <= idx_i;
          j        <= idx_j;
          drop_cnt <= drop_cnt + 16'd1;
        end
        ST_STREAM: begin
          if (stream_step) begin
            i       <= idx_i;
            j       <= idx_j;
            vld_p0  <= 1'b1;
            data_p0 <= mode_l ? (in_data ^ val_t) : val_t;
          end else if (out_ready) begin
            vld_p0 <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
